// File: rtl/lfsr_prbs_gen_chk_pkg.sv
// Shared types and combinational helpers for the PRBS generator/checker.
// Helpers work on 32-bit (state) and 64-bit (word) containers; callers
// zero-extend their narrower values, so the upper bits never affect results.
package lfsr_prbs_gen_chk_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // One Galois step: the bit leaving state[0] is the sequence bit.
    // If that bit is 1, the feedback mask is folded back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                              input logic [31:0] fb);
        return (state >> 1) ^ (state[0] ? fb : 32'd0);
    endfunction

    // Next sequence bit from the history of past bits (hist[0] = newest).
    function automatic logic lfsr_predict(input logic [31:0] hist,
                                          input logic [31:0] fb);
        return ^(hist & fb);
    endfunction

    // Number of set bits in a word of up to 64 bits.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr_prbs_gen_chk_chk.sv
// Self-synchronising PRBS checker: locks onto a received stream of the
// same polynomial, counts bit errors and drops lock on sustained errors.
module lfsr_prbs_gen_chk_chk
    import lfsr_prbs_gen_chk_pkg::*;
#(
    parameter int            N          = 8,
    parameter logic [N-1:0]  FB         = 8'h8e,
    parameter int            W          = 8,
    parameter int            LOCK_CNT   = 4,
    parameter int            UNLOCK_CNT = 4,
    parameter int            CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  i_chk_in,
    input  logic          i_chk_valid,
    input  logic          i_clr_cnt,
    output logic          o_locked,
    output logic          o_err_word,
    output logic [CW-1:0] o_err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    // Add a word's error count to the accumulator, clamping at all-ones.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                              input logic [6:0]    b);
        logic [CW+7:0] s;
        s = (CW+8)'(a) + (CW+8)'(b);
        if (|s[CW+7:CW]) begin
            return '1;
        end
        return s[CW-1:0];
    endfunction

    chk_state_t     r_state;
    logic [N-1:0]   r_hist;
    logic [MW-1:0]  r_match_cnt;
    logic [UW-1:0]  r_miss_cnt;
    logic           r_locked;
    logic           r_err_word;
    logic [CW-1:0]  r_err_cnt;

    logic [N-1:0]   w_h;
    logic           w_p;
    logic [W-1:0]   w_err;
    logic [N-1:0]   w_next_hist;
    logic [6:0]     w_pop;
    logic           w_any_err;
    logic [CW-1:0]  w_cnt_base;

    // Unroll the bit recurrence across the word; while locked the history is
    // fed with predictions so a corrupted bit cannot poison later predictions.
    always_comb begin
        w_h   = r_hist;
        w_p   = 1'b0;
        w_err = '0;
        for (int j = 0; j < W; j++) begin
            w_p      = lfsr_predict(32'(w_h), 32'(FB));
            w_err[j] = w_p ^ i_chk_in[j];
            w_h      = {w_h[N-2:0], (r_state == LOCKED) ? w_p : i_chk_in[j]};
        end
        w_next_hist = w_h;
        w_pop       = popcount(64'(w_err));
        w_any_err   = |w_err;
        w_cnt_base  = i_clr_cnt ? '0 : r_err_cnt;
    end

    // Checker FSM with history, match/miss counters and error accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_hist      <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_word  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_word <= 1'b0;
            if (i_clr_cnt) begin
                r_err_cnt <= '0;
            end
            if (i_chk_valid) begin
                r_hist <= w_next_hist;
                case (r_state)
                    SEARCH: begin
                        if (w_any_err) begin
                            r_match_cnt <= '0;
                        end else if (r_match_cnt == MW'(LOCK_CNT - 1)) begin
                            r_state     <= LOCKED;
                            r_locked    <= 1'b1;
                            r_match_cnt <= '0;
                            r_miss_cnt  <= '0;
                        end else begin
                            r_match_cnt <= r_match_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        r_err_word <= w_any_err;
                        r_err_cnt  <= sat_add(w_cnt_base, w_pop);
                        if (w_any_err) begin
                            if (r_miss_cnt == UW'(UNLOCK_CNT - 1)) begin
                                r_state     <= SEARCH;
                                r_locked    <= 1'b0;
                                r_match_cnt <= '0;
                                r_miss_cnt  <= '0;
                            end else begin
                                r_miss_cnt <= r_miss_cnt + 1'b1;
                            end
                        end else begin
                            r_miss_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                    end
                endcase
            end
        end
    end

    assign o_locked   = r_locked;
    assign o_err_word = r_err_word;
    assign o_err_cnt  = r_err_cnt;

endmodule

// File: rtl/lfsr_prbs_gen_chk.sv
// PRBS pattern source (Galois LFSR, W bits per enable) plus the matching
// checker. Generator and checker are independent; loopback is external.
module lfsr_prbs_gen_chk
    import lfsr_prbs_gen_chk_pkg::*;
#(
    parameter int            N          = 8,
    parameter logic [N-1:0]  FB         = 8'h8e,
    parameter logic [N-1:0]  INIT       = 8'hff,
    parameter int            W          = 8,
    parameter int            LOCK_CNT   = 4,
    parameter int            UNLOCK_CNT = 4,
    parameter int            CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [N-1:0]  i_seed,
    input  logic          i_en,
    output logic [W-1:0]  o_gen_out,
    output logic          o_gen_valid,
    input  logic [W-1:0]  i_chk_in,
    input  logic          i_chk_valid,
    input  logic          i_clr_cnt,
    output logic          o_locked,
    output logic          o_err_word,
    output logic [CW-1:0] o_err_cnt
);

    logic [N-1:0] r_state;
    logic [W-1:0] r_gen_out;
    logic         r_gen_valid;

    logic [N-1:0] w_walk;
    logic [W-1:0] w_word;
    logic [N-1:0] w_next_state;
    logic [N-1:0] w_seed_eff;

    // Walk the LFSR W steps, collecting the bit that leaves state[0] each step.
    always_comb begin
        w_walk = r_state;
        w_word = '0;
        for (int j = 0; j < W; j++) begin
            w_word[j] = w_walk[0];
            w_walk    = N'(lfsr_step(32'(w_walk), 32'(FB)));
        end
        w_next_state = w_walk;
        w_seed_eff   = (i_seed == '0) ? INIT : i_seed;
    end

    // Generator register: load wins over enable; valid pulses only on enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_gen_out   <= '0;
            r_gen_valid <= 1'b0;
        end else if (i_load) begin
            r_state     <= w_seed_eff;
            r_gen_valid <= 1'b0;
        end else if (i_en) begin
            r_state     <= w_next_state;
            r_gen_out   <= w_word;
            r_gen_valid <= 1'b1;
        end else begin
            r_gen_valid <= 1'b0;
        end
    end

    assign o_gen_out   = r_gen_out;
    assign o_gen_valid = r_gen_valid;

    lfsr_prbs_gen_chk_chk #(
        .N          (N),
        .FB         (FB),
        .W          (W),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .CW         (CW)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_chk_in    (i_chk_in),
        .i_chk_valid (i_chk_valid),
        .i_clr_cnt   (i_clr_cnt),
        .o_locked    (o_locked),
        .o_err_word  (o_err_word),
        .o_err_cnt   (o_err_cnt)
    );

endmodule

// File: tb/tb_lfsr_prbs_gen_chk.sv
// Directed bench for lfsr_prbs_gen_chk: W=8 generator table, W=1 sequence
// and period, loopback lock/error/unlock, and a CW=4 saturation instance.
module tb_lfsr_prbs_gen_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- W=8 instance, loopback through a flip mask
    logic        rst8 = 1'b1, ld8 = 1'b0, en8 = 1'b0, clr8 = 1'b0, cven8 = 1'b0;
    logic [7:0]  seed8 = 8'h00, flip8 = 8'h00;
    logic [7:0]  go8, ci8;
    logic        gv8, cv8, lk8, ew8;
    logic [15:0] ec8;
    assign ci8 = go8 ^ flip8;
    assign cv8 = gv8 & cven8;

    lfsr_prbs_gen_chk u8 (
        .clk(clk), .rst(rst8), .i_load(ld8), .i_seed(seed8), .i_en(en8),
        .o_gen_out(go8), .o_gen_valid(gv8), .i_chk_in(ci8), .i_chk_valid(cv8),
        .i_clr_cnt(clr8), .o_locked(lk8), .o_err_word(ew8), .o_err_cnt(ec8)
    );

    // ---------------- W=1 instance
    logic        rst1 = 1'b1, ld1 = 1'b0, en1 = 1'b0, clr1 = 1'b0;
    logic [7:0]  seed1 = 8'h00;
    logic [0:0]  go1;
    logic        gv1, lk1, ew1;
    logic [15:0] ec1;

    lfsr_prbs_gen_chk #(.W(1)) u1 (
        .clk(clk), .rst(rst1), .i_load(ld1), .i_seed(seed1), .i_en(en1),
        .o_gen_out(go1), .o_gen_valid(gv1), .i_chk_in(go1), .i_chk_valid(gv1),
        .i_clr_cnt(clr1), .o_locked(lk1), .o_err_word(ew1), .o_err_cnt(ec1)
    );

    // ---------------- saturation instance: CW=4, UNLOCK_CNT=255
    logic        rsts = 1'b1, lds = 1'b0, ens = 1'b0, clrs = 1'b0, cvens = 1'b0;
    logic [7:0]  seeds = 8'h00, flips = 8'h00;
    logic [7:0]  gos, cis;
    logic        gvs, cvs, lks, ews;
    logic [3:0]  ecs;
    assign cis = gos ^ flips;
    assign cvs = gvs & cvens;

    lfsr_prbs_gen_chk #(.CW(4), .UNLOCK_CNT(255)) us (
        .clk(clk), .rst(rsts), .i_load(lds), .i_seed(seeds), .i_en(ens),
        .o_gen_out(gos), .o_gen_valid(gvs), .i_chk_in(cis), .i_chk_valid(cvs),
        .i_clr_cnt(clrs), .o_locked(lks), .o_err_word(ews), .o_err_cnt(ecs)
    );

    typedef struct {
        logic       ld;
        logic [7:0] seed;
        logic       en;
        logic [7:0] exp_out;
        logic       exp_vld;
    } gvec_t;

    typedef struct {
        logic       b;
        logic [7:0] st;
    } bvec_t;

    gvec_t gtab[7];
    bvec_t btab[8];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwords;
        int lock_at;
        int bad;
        int steps;
        logic v;

        // Generator word table (W=8, from reset state ff).
        gtab[0] = '{1'b0, 8'h00, 1'b1, 8'h7b, 1'b1};
        gtab[1] = '{1'b0, 8'h00, 1'b0, 8'h7b, 1'b0};
        gtab[2] = '{1'b1, 8'h00, 1'b1, 8'h7b, 1'b0};
        gtab[3] = '{1'b0, 8'h00, 1'b1, 8'h7b, 1'b1};
        gtab[4] = '{1'b1, 8'h7e, 1'b0, 8'h7b, 1'b0};
        gtab[5] = '{1'b0, 8'h00, 1'b1, 8'h76, 1'b1};
        gtab[6] = '{1'b0, 8'h00, 1'b1, 8'ha7, 1'b1};

        // W=1: sequence bit and state after each step, starting at ff.
        btab[0] = '{1'b1, 8'hf1};
        btab[1] = '{1'b1, 8'hf6};
        btab[2] = '{1'b0, 8'h7b};
        btab[3] = '{1'b1, 8'hb3};
        btab[4] = '{1'b1, 8'hd7};
        btab[5] = '{1'b1, 8'he5};
        btab[6] = '{1'b1, 8'hfc};
        btab[7] = '{1'b0, 8'h7e};

        @(posedge clk); #1;
        chk("rst_gen_out",   64'(go8), 64'h0);
        chk("rst_gen_valid", 64'(gv8), 64'h0);
        chk("rst_locked",    64'(lk8), 64'h0);
        chk("rst_err_word",  64'(ew8), 64'h0);
        chk("rst_err_cnt",   64'(ec8), 64'h0);
        chk("rst_state",     64'(u8.r_state), 64'hff);

        // Table-driven generator vectors.
        @(negedge clk);
        rst8 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ld8   = gtab[i].ld;
            seed8 = gtab[i].seed;
            en8   = gtab[i].en;
            @(posedge clk); #1;
            chk($sformatf("gen_out[%0d]", i),   64'(go8), 64'(gtab[i].exp_out));
            chk($sformatf("gen_valid[%0d]", i), 64'(gv8), 64'(gtab[i].exp_vld));
            if (i == 0) chk("state_after_word", 64'(u8.r_state), 64'h7e);
            if (i == 2) chk("load_zero_seed",   64'(u8.r_state), 64'hff);
            @(negedge clk);
        end
        ld8 = 1'b0;
        en8 = 1'b0;

        // W=1 sequence and period.
        rst1 = 1'b0;
        en1  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("w1_bit[%0d]", k),   64'(go1), 64'(btab[k].b));
            chk($sformatf("w1_state[%0d]", k), 64'(u1.r_state), 64'(btab[k].st));
        end
        chk("w1_valid", 64'(gv1), 64'h1);
        steps = 8;
        while (u1.r_state != 8'hff && steps < 300) begin
            @(posedge clk); #1;
            steps++;
        end
        chk("w1_period", 64'(steps), 64'd255);
        @(negedge clk);
        en1 = 1'b0;

        // Loopback lock: the first word is predicted from an all-zero
        // history and cannot match, so four matches end on the fifth word.
        rst8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst8  = 1'b0;
        en8   = 1'b1;
        cven8 = 1'b1;
        flip8 = 8'h00;
        nwords  = 0;
        lock_at = 0;
        for (int c = 0; c < 20 && lock_at == 0; c++) begin
            @(negedge clk);
            v = cv8;
            @(posedge clk); #1;
            if (v) nwords++;
            if (lk8) lock_at = nwords;
        end
        chk("lock_word", 64'(lock_at), 64'd5);
        bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (ec8 != 16'd0 || lk8 != 1'b1 || ew8 != 1'b0) bad++;
        end
        chk("loopback_1000_clean", 64'(bad), 64'd0);

        // Two-bit error in one locked word.
        @(negedge clk);
        flip8 = 8'h21;
        @(posedge clk); #1;
        chk("flip2_err_word", 64'(ew8), 64'h1);
        chk("flip2_err_cnt",  64'(ec8), 64'd2);
        chk("flip2_locked",   64'(lk8), 64'h1);
        @(negedge clk);
        flip8 = 8'h00;
        @(posedge clk); #1;
        chk("flip2_err_word_drop", 64'(ew8), 64'h0);

        // Idle checker input: nothing changes even with a corrupt word present.
        @(negedge clk);
        en8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flip8 = 8'hff;
        @(posedge clk); #1;
        chk("idle_err_word", 64'(ew8), 64'h0);
        chk("idle_err_cnt",  64'(ec8), 64'd2);
        chk("idle_locked",   64'(lk8), 64'h1);
        @(negedge clk);
        flip8 = 8'h00;
        en8   = 1'b1;
        @(posedge clk);

        // Four consecutive errored words drop lock.
        @(negedge clk);
        flip8 = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        chk("unlock_3_locked", 64'(lk8), 64'h1);
        chk("unlock_3_errw",   64'(ew8), 64'h1);
        @(posedge clk); #1;
        chk("unlock_4_locked", 64'(lk8), 64'h0);
        chk("unlock_4_errcnt", 64'(ec8), 64'd6);

        // Clean words relock after four matches.
        @(negedge clk);
        flip8 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("relock_3", 64'(lk8), 64'h0);
        @(posedge clk); #1;
        chk("relock_4", 64'(lk8), 64'h1);
        chk("relock_errcnt", 64'(ec8), 64'd6);

        // Saturation instance.
        @(negedge clk);
        rsts  = 1'b0;
        ens   = 1'b1;
        cvens = 1'b1;
        for (int c = 0; c < 20 && lks == 1'b0; c++) begin
            @(posedge clk); #1;
        end
        chk("sat_lock", 64'(lks), 64'h1);
        @(negedge clk);
        flips = 8'hff;
        @(posedge clk); #1;
        chk("sat_cnt_8", 64'(ecs), 64'd8);
        @(posedge clk); #1;
        chk("sat_cnt_15", 64'(ecs), 64'd15);
        @(posedge clk); #1;
        chk("sat_cnt_hold", 64'(ecs), 64'd15);
        chk("sat_locked",   64'(lks), 64'h1);
        @(negedge clk);
        flips = 8'h00;
        clrs  = 1'b1;
        @(posedge clk); #1;
        chk("sat_clr", 64'(ecs), 64'd0);
        @(negedge clk);
        clrs  = 1'b0;
        flips = 8'hff;
        @(posedge clk); #1;
        chk("sat_reaccum", 64'(ecs), 64'd8);
        @(negedge clk);
        flips = 8'h03;
        clrs  = 1'b1;
        @(posedge clk); #1;
        chk("clr_with_err", 64'(ecs), 64'd2);

        // Reset mid-stream with enable, load and valid all active.
        @(negedge clk);
        clrs  = 1'b0;
        flips = 8'hff;
        lds   = 1'b1;
        rsts  = 1'b1;
        @(posedge clk); #1;
        chk("midrst_locked",   64'(lks), 64'h0);
        chk("midrst_err_cnt",  64'(ecs), 64'd0);
        chk("midrst_err_word", 64'(ews), 64'h0);
        chk("midrst_gen_vld",  64'(gvs), 64'h0);
        chk("midrst_gen_out",  64'(gos), 64'h0);
        chk("midrst_state",    64'(us.r_state), 64'hff);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
